rng_stream: RTL and testbench
=============================

# rng_stream

Parametrised pseudo-random stream generator; successor to the fixed 4-bit LFSR/NLFSR selector. It runs a WIDTH-bit Fibonacci LFSR and a WIDTH-bit NLFSR in lockstep and adds a combined (XOR) output and a one-hot output derived from the combined value. Samples are delivered through a registered valid/ready output stage with backpressure, and the block raises a reseed request after a programmable number of delivered samples. It sits between the chip I/O wrapper and any downstream sample consumer.

## Interface
Parameters:
- WIDTH, 8, generator and output width; power of two, 4..32.
- LFSR_TAPS, 8'hB8, LFSR feedback mask, WIDTH bits.
- NLFSR_TAPS, 8'h8E, NLFSR linear feedback mask, WIDTH bits.
- RESET_SEED, 1, nonzero seed applied at reset.
- RESEED_INTERVAL, 256, captured-sample count that triggers reseed_req; must be at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- mode  in  2  output select, sampled at capture.
- seed  in  WIDTH  seed value.
- seed_load  in  1  loads seed into both generators.
- enable  in  1  permits generation.
- out_ready  in  1  consumer accepts out_data.
- out_valid  out  1  out_data holds an unconsumed sample.
- out_data  out  WIDTH  sample.
- reseed_req  out  1  sticky; RESEED_INTERVAL samples have been captured since the last seed or reset.

## Operation
- Next LFSR state is `{lfsr[W-2:0], ^(lfsr & LFSR_TAPS)}`.
- Next NLFSR state is `{nl[W-2:0], ^(nl & NLFSR_TAPS) ^ (nl[1] & nl[2])}`. If that result is all-zero, load 1 instead (lockup escape).
- Seed fix: s = seed, or 1 if seed == 0. Load lfsr <= s and nl <= bit-reverse(s).
- Reset: lfsr <= RESET_SEED, nl <= bit-reverse(RESET_SEED), out_valid = 0, out_data = 0, reseed_req = 0, sample counter = 0.
- Priority per cycle is reset > seed_load > capture.
- seed_load: applies the seed fix, clears out_valid, clears the counter and reseed_req. No capture happens that cycle.
- Capture condition is enable && !seed_load && (!out_valid || out_ready). On capture:
  - Both generators step.
  - out_data <= f(mode, new lfsr, new nl), and out_valid <= 1.
  - The counter increments, saturating at RESEED_INTERVAL.
  - reseed_req <= 1 on the capture that brings the counter to RESEED_INTERVAL. Generation continues normally afterwards.
- Output function f:
  - mode 00: lfsr.
  - mode 01: nl.
  - mode 10: c = lfsr ^ nl.
  - mode 11: one-hot, 1 << c[log2(WIDTH)-1:0].
- No capture and out_valid && out_ready: out_valid <= 0, and out_data holds its last value.
- No capture and no handshake: all state holds. Generators never advance while a sample is stalled.
- A mode change while out_valid is high does not alter the held out_data.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency: out_valid rises on the first clock edge where enable is high (empty stage).
- Throughput: one sample per cycle when enable and out_ready are both held high.
- seed_load pulse at edge N: the first sample from the new seed appears at edge N+1 if enable is high.
- Reset mid-stream: the pending sample is discarded and out_valid is 0 on the next cycle.
- out_data is stable whenever out_valid && !out_ready.

## Test plan
- Reset, then idle with enable = 0 -> out_valid = 0, out_data = 0x00, reseed_req = 0, held indefinitely.
- WIDTH = 8 defaults, mode 00, enable = 1, out_ready = 1 -> out_data sequence 0x02, 0x04, 0x08, 0x11, 0x23 on consecutive cycles, out_valid high throughout.
- Same setup, mode 01 -> nl sequence 0x01, 0x02, 0x05, 0x0B. Mode 10 first sample -> 0x03. Mode 11 first sample -> 0x08.
- Mode 00, out_ready held low for 3 cycles after the first sample -> out_data stays 0x02. Raising out_ready then yields 0x04 on the next edge, with no skipped values.
- seed_load = 1 with seed = 0x00 while out_valid = 1 -> out_valid drops. The next mode 00 sample is 0x02, exactly as for reset seed 1.
- RESEED_INTERVAL = 4, continuous capture -> reseed_req rises with the 4th sample and stays high while generation continues. A seed_load pulse clears it, and it rises again after 4 more samples.

Source files
------------

// File: rtl/rng_stream.sv
// rng_stream: LFSR/NLFSR pseudo-random sample stream with valid/ready output and reseed request
module rng_stream #(
    parameter int              WIDTH           = 8,
    parameter logic [WIDTH-1:0] LFSR_TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] NLFSR_TAPS     = 8'h8E,
    parameter logic [WIDTH-1:0] RESET_SEED     = 1,
    parameter int              RESEED_INTERVAL = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             enable,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             reseed_req
);
    localparam int LW = $clog2(WIDTH);
    localparam int CW = $clog2(RESEED_INTERVAL + 1);
    localparam logic [CW-1:0] RI = CW'(RESEED_INTERVAL);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    logic [WIDTH-1:0] lfsr, nl, lfsr_nx, nl_raw, nl_nx, seed_fix, mix, f_val;
    logic [CW-1:0]    cnt;
    logic             capture;

    // next generator states, output selection and capture decision
    always_comb begin
        lfsr_nx  = {lfsr[WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
        nl_raw   = {nl[WIDTH-2:0], ^(nl & NLFSR_TAPS) ^ (nl[1] & nl[2])};
        nl_nx    = (nl_raw == '0) ? ONE : nl_raw;
        seed_fix = (seed == '0) ? ONE : seed;
        mix      = lfsr_nx ^ nl_nx;
        f_val    = (mode == 2'b00) ? lfsr_nx :
                   (mode == 2'b01) ? nl_nx :
                   (mode == 2'b10) ? mix : (ONE << mix[LW-1:0]);
        capture  = enable && !seed_load && (!out_valid || out_ready);
    end

    // generator, output stage and sample counter state; reset > seed_load > capture
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= RESET_SEED;
            nl         <= rev(RESET_SEED);
            out_valid  <= 1'b0;
            out_data   <= '0;
            reseed_req <= 1'b0;
            cnt        <= '0;
        end else if (seed_load) begin
            lfsr       <= seed_fix;
            nl         <= rev(seed_fix);
            out_valid  <= 1'b0;
            reseed_req <= 1'b0;
            cnt        <= '0;
        end else if (capture) begin
            lfsr      <= lfsr_nx;
            nl        <= nl_nx;
            out_data  <= f_val;
            out_valid <= 1'b1;
            cnt       <= (cnt == RI) ? cnt : cnt + 1'b1;
            if (cnt == RI - 1'b1) reseed_req <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rng_stream.sv
// tb_rng_stream: directed checks of sequences, backpressure, seeding and reseed request
module tb_rng_stream;
    logic       clk = 0;
    logic       reset, seed_load, enable, out_ready, out_valid, reseed_req;
    logic [1:0] mode;
    logic [7:0] seed, out_data;
    int         total = 0, bad = 0;

    rng_stream #(.RESEED_INTERVAL(4)) dut (
        .clk(clk), .reset(reset), .mode(mode), .seed(seed), .seed_load(seed_load),
        .enable(enable), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .reseed_req(reseed_req)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; seed_load = 0; out_ready = 1;
        step();
        check("rst_valid", out_valid, 0);
        reset = 0;
    endtask

    initial begin
        reset = 1; enable = 0; seed_load = 0; out_ready = 1; mode = 0; seed = 0;
        step();
        step();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_valid", out_valid, 0);
            check("idle_data", out_data, 8'h00);
            check("idle_reseed", reseed_req, 0);
        end
        enable = 1;
        step(); check("m0_s1", out_data, 8'h02); check("m0_v1", out_valid, 1);
        step(); check("m0_s2", out_data, 8'h04);
        step(); check("m0_s3", out_data, 8'h08); check("rq_before4", reseed_req, 0);
        step(); check("m0_s4", out_data, 8'h11); check("rq_at4", reseed_req, 1);
        step(); check("m0_s5", out_data, 8'h23); check("m0_v5", out_valid, 1);
        check("rq_sticky", reseed_req, 1);
        do_reset();
        check("rst_reseed", reseed_req, 0);
        mode = 1; enable = 1;
        step(); check("m1_s1", out_data, 8'h01);
        step(); check("m1_s2", out_data, 8'h02);
        step(); check("m1_s3", out_data, 8'h05);
        step(); check("m1_s4", out_data, 8'h0B);
        do_reset();
        mode = 2; enable = 1;
        step(); check("m2_s1", out_data, 8'h03);
        do_reset();
        mode = 3; enable = 1;
        step(); check("m3_s1", out_data, 8'h08);
        do_reset();
        mode = 0; enable = 1; out_ready = 0;
        step(); check("bp_first", out_data, 8'h02); check("bp_v", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) mode = 2;
            step();
            check("bp_hold", out_data, 8'h02);
            check("bp_hold_v", out_valid, 1);
        end
        mode = 0; out_ready = 1;
        step(); check("bp_release", out_data, 8'h04);
        step(); check("bp_next", out_data, 8'h08);
        seed = 8'h00; seed_load = 1;
        step(); check("sl_valid", out_valid, 0); check("sl_reseed", reseed_req, 0);
        seed_load = 0;
        step(); check("sl_s1", out_data, 8'h02); check("sl_v1", out_valid, 1);
        step(); check("sl_s2", out_data, 8'h04);
        step(); check("sl_s3", out_data, 8'h08); check("sl_rq3", reseed_req, 0);
        step(); check("sl_s4", out_data, 8'h11); check("sl_rq4", reseed_req, 1);
        enable = 0;
        step(); check("drain_v", out_valid, 0); check("drain_data", out_data, 8'h11);
        seed = 8'h5A; seed_load = 1;
        step(); check("sl2_rq", reseed_req, 0);
        seed_load = 0; enable = 1;
        step(); check("seed5a_s1", out_data, 8'hB4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
